// File: rtl/axi4_sram_mst_if.sv
// rtl/axi4_sram_mst_if.sv - AXI4 bus bundle between the SRAM-style initiator and its responder
interface axi4_sram_mst_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_sram_mst.sv
// rtl/axi4_sram_mst.sv - single-beat AXI4 initiator behind an SRAM-style request port
// Optional response watchdog with DRAIN state: define AXI4_SRAM_MST_TIMEOUT_EN.
module axi4_sram_mst #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int ID_WIDTH       = 4,
   parameter int MST_ID         = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_wen_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH/8-1:0] req_bm_i,
   input  logic [DATA_WIDTH-1:0]   req_dat_i,
   output logic                    rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic                    rsp_err_o,
   axi4_sram_mst_if.master         axi
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int SIZE   = $clog2(STRB_W);
   localparam logic [ID_WIDTH-1:0]   OWN_ID     = ID_WIDTH'(MST_ID);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_RSP   = 3'd5;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [STRB_W-1:0]     bm_q;
   logic                  aw_done;
   logic                  w_done;
   logic                  drain_b;
   logic                  drain_r;
   logic                  unused_bits;

`ifdef AXI4_SRAM_MST_TIMEOUT_EN
   localparam logic [2:0] S_DRAIN = 3'd6;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             tmo_q;
   logic             wen_q;

   // The late response is still owed by the responder; soak it up on the matching channel.
   assign drain_b = (state == S_DRAIN) && wen_q;
   assign drain_r = (state == S_DRAIN) && !wen_q;
`else
   assign drain_b = 1'b0;
   assign drain_r = 1'b0;
`endif

   assign unused_bits = ^{axi.bresp[0], axi.rresp[0]};

   // Reset gating keeps req_ready_o low while aresetn is held, even though state reads IDLE.
   assign req_ready_o = (state == S_IDLE) && aresetn;
   assign rsp_valid_o = (state == S_RSP);

   assign axi.awid    = OWN_ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 8'd0;
   assign axi.awsize  = 3'(SIZE);
   assign axi.awburst = 2'b01;
   assign axi.awvalid = (state == S_WADDR) && !aw_done;
   assign axi.wdata   = dat_q;
   assign axi.wstrb   = bm_q;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = (state == S_WADDR) && !w_done;
   assign axi.bready  = (state == S_WRESP) || drain_b;
   assign axi.arid    = OWN_ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = 3'(SIZE);
   assign axi.arburst = 2'b01;
   assign axi.arvalid = (state == S_RADDR);
   assign axi.rready  = (state == S_RDATA) || drain_r;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         dat_q     <= '0;
         bm_q      <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_dat_o <= '0;
         rsp_err_o <= 1'b0;
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
         cnt       <= '0;
         tmo_q     <= 1'b0;
         wen_q     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  addr_q  <= req_addr_i & ALIGN_MASK;
                  dat_q   <= req_dat_i;
                  bm_q    <= req_bm_i;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= req_wen_i ? S_WADDR : S_RADDR;
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
                  wen_q   <= req_wen_i;
`endif
               end
            end
            S_WADDR: begin
               if (axi.awready) aw_done <= 1'b1;
               if (axi.wready)  w_done  <= 1'b1;
               if ((aw_done || axi.awready) && (w_done || axi.wready)) begin
                  state <= S_WRESP;
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end
            end
            S_WRESP: begin
               if (axi.bvalid) begin
                  rsp_err_o <= axi.bresp[1] | (axi.bid != OWN_ID);
                  state     <= S_RSP;
               end
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
               else if (cnt == CNT_LAST) begin
                  rsp_err_o <= 1'b1;
                  tmo_q     <= 1'b1;
                  state     <= S_RSP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            S_RADDR: begin
               if (axi.arready) begin
                  state <= S_RDATA;
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end
            end
            S_RDATA: begin
               if (axi.rvalid) begin
                  rsp_dat_o <= axi.rdata;
                  rsp_err_o <= axi.rresp[1] | ~axi.rlast | (axi.rid != OWN_ID);
                  state     <= S_RSP;
               end
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
               else if (cnt == CNT_LAST) begin
                  rsp_err_o <= 1'b1;
                  tmo_q     <= 1'b1;
                  state     <= S_RSP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            S_RSP: begin
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
               tmo_q <= 1'b0;
               state <= tmo_q ? S_DRAIN : S_IDLE;
`else
               state <= S_IDLE;
`endif
            end
`ifdef AXI4_SRAM_MST_TIMEOUT_EN
            S_DRAIN: begin
               if ((wen_q && axi.bvalid) || (!wen_q && axi.rvalid)) state <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_sram_mst.sv
// tb/tb_axi4_sram_mst.sv - scoreboard bench for axi4_sram_mst with a configurable AXI responder
module tb_axi4_sram_mst;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int IW  = 4;
   localparam int MID = 3;
   localparam int TMO = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_wen_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [7:0]    req_bm_i = '0;
   logic [DW-1:0] req_dat_i = '0;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_dat_o;
   logic          rsp_err_o;

   always #5 aclk = ~aclk;

   axi4_sram_mst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

   axi4_sram_mst #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MST_ID(MID), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
      .req_addr_i(req_addr_i), .req_bm_i(req_bm_i), .req_dat_i(req_dat_i),
      .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
      .axi(axi)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic        err;
      logic [63:0] dat;
      int          lat;
      int          acc;
      string       tag;
   } exp_t;
   exp_t sb[$];

   always @(posedge aclk) cyc <= cyc + 1;

   // Responder configuration and captured request fields
   int          aw_wait = 0, w_wait = 0;
   logic        b_en = 1'b1, r_en = 1'b1;
   logic [1:0]  bresp_c = 2'b00, rresp_c = 2'b00;
   logic [3:0]  bid_c = 4'(MID), rid_c = 4'(MID);
   logic        rlast_c = 1'b1;
   logic [63:0] rdata_c = '0;
   logic [31:0] cap_awaddr, cap_araddr;
   logic [63:0] cap_wdata;
   logic [7:0]  cap_wstrb, cap_awlen, cap_arlen;
   logic [2:0]  cap_awsize, cap_arsize;
   logic [1:0]  cap_awburst, cap_arburst;
   logic [3:0]  cap_awid, cap_arid;
   logic        cap_wlast;
   int          aw_cyc = 0, w_cyc = 0, aw_seen = 0, w_seen = 0;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, b_pend, r_pend;

   initial begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
      axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rid = '0;
   end

   // Handshakes decided at a negedge complete at the following posedge and are acted on one negedge later.
   always @(negedge aclk) begin
      if (!aresetn) begin
         {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, b_pend, r_pend} = '0;
         aw_seen = 0; w_seen = 0;
         axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
         axi.bvalid = 1'b0; axi.rvalid = 1'b0;
      end else begin
         if (aw_hs) aw_got = 1'b1;
         if (w_hs)  w_got = 1'b1;
         if (aw_got && w_got) begin b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
         if (b_hs)  b_pend = 1'b0;
         if (ar_hs) r_pend = 1'b1;
         if (r_hs)  r_pend = 1'b0;
         axi.awready = axi.awvalid && (aw_seen >= aw_wait);
         aw_seen = axi.awvalid ? aw_seen + 1 : 0;
         if (axi.awvalid) aw_cyc++;
         axi.wready = axi.wvalid && (w_seen >= w_wait);
         w_seen = axi.wvalid ? w_seen + 1 : 0;
         if (axi.wvalid) w_cyc++;
         axi.arready = axi.arvalid;
         axi.bvalid = b_pend && b_en; axi.bresp = bresp_c; axi.bid = bid_c;
         axi.rvalid = r_pend && r_en; axi.rdata = rdata_c; axi.rresp = rresp_c;
         axi.rlast = rlast_c; axi.rid = rid_c;
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         ar_hs = axi.arvalid && axi.arready;
         b_hs  = axi.bvalid && axi.bready;
         r_hs  = axi.rvalid && axi.rready;
         if (aw_hs) begin
            cap_awaddr = axi.awaddr; cap_awlen = axi.awlen; cap_awsize = axi.awsize;
            cap_awburst = axi.awburst; cap_awid = axi.awid;
         end
         if (w_hs) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; cap_wlast = axi.wlast; end
         if (ar_hs) begin
            cap_araddr = axi.araddr; cap_arlen = axi.arlen; cap_arsize = axi.arsize;
            cap_arburst = axi.arburst; cap_arid = axi.arid;
         end
      end
   end

   always @(negedge aclk) begin
      if (aresetn && rsp_valid_o) begin
         if (sb.size() == 0) begin
            check("spurious_rsp", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_err"}, rsp_err_o, e.err);
            check({e.tag, "_dat"}, rsp_dat_o, e.dat);
            if (e.lat > 0) check({e.tag, "_lat"}, cyc - e.acc, e.lat);
         end
      end
   end

   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [63:0] dat,
                         input logic [7:0] bm, input logic push, input logic eerr,
                         input logic [63:0] edat, input int lat, input string tag);
      int n = 0;
      @(negedge aclk);
      while (!req_ready_o && n < 200) begin @(negedge aclk); n++; end
      if (!req_ready_o) check({tag, "_accept_timeout"}, 1'b0, 1'b1);
      req_valid_i = 1'b1; req_wen_i = wen; req_addr_i = addr; req_dat_i = dat; req_bm_i = bm;
      if (push) begin
         exp_t e;
         e.err = eerr; e.dat = edat; e.lat = lat; e.acc = cyc; e.tag = tag;
         sb.push_back(e);
      end
      @(negedge aclk);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((sb.size() != 0 || !req_ready_o) && n < 200) begin @(negedge aclk); n++; end
      if (sb.size() != 0 || !req_ready_o) begin
         check({tag, "_idle_timeout"}, 1'b0, 1'b1);
         sb.delete();
      end
   endtask

   logic [63:0] last_rd;

   initial begin
      last_rd = '0;
      repeat (3) @(negedge aclk);
      check("rst_req_ready", req_ready_o, 1'b0);
      check("rst_rsp_valid", rsp_valid_o, 1'b0);
      check("rst_bus_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
      check("rst_rsp_dat", rsp_dat_o, 64'd0);
      check("rst_rsp_err", rsp_err_o, 1'b0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("idle_req_ready", req_ready_o, 1'b1);

      do_req(1'b1, 32'h1004, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 1'b0, last_rd, 3, "wr");
      wait_idle("wr");
      check("wr_awaddr", cap_awaddr, 32'h1000);
      check("wr_wstrb", cap_wstrb, 8'hFF);
      check("wr_wdata", cap_wdata, 64'hDEADBEEF_CAFEF00D);
      check("wr_wlast", cap_wlast, 1'b1);
      check("wr_awlen", cap_awlen, 8'd0);
      check("wr_awsize", cap_awsize, 3'd3);
      check("wr_awburst", cap_awburst, 2'b01);
      check("wr_awid", cap_awid, 4'(MID));

      rdata_c = 64'h0123456789ABCDEF;
      do_req(1'b0, 32'h2000, '0, '0, 1'b1, 1'b0, rdata_c, 3, "rd");
      wait_idle("rd");
      last_rd = rdata_c;
      check("rd_araddr", cap_araddr, 32'h2000);
      check("rd_arlen_size_burst", {cap_arlen, cap_arsize, cap_arburst}, {8'd0, 3'd3, 2'b01});
      check("rd_arid", cap_arid, 4'(MID));

      rdata_c = 64'hA5A5_0000_FFFF_1234;
      do_req(1'b0, 32'h300F, '0, '0, 1'b1, 1'b0, rdata_c, 3, "rd_unaligned");
      wait_idle("rd_unaligned");
      last_rd = rdata_c;
      check("rd_unaligned_araddr", cap_araddr, 32'h3008);

      aw_wait = 3; w_wait = 0; aw_cyc = 0; w_cyc = 0;
      do_req(1'b1, 32'h0040, 64'h1111_2222_3333_4444, 8'h0F, 1'b1, 1'b0, last_rd, 6, "wr_split");
      wait_idle("wr_split");
      check("wr_split_aw_cycles", aw_cyc, 4);
      check("wr_split_w_cycles", w_cyc, 1);
      check("wr_split_wstrb", cap_wstrb, 8'h0F);
      aw_wait = 0;

      bresp_c = 2'b10;
      do_req(1'b1, 32'h0080, 64'h5, 8'h01, 1'b1, 1'b1, last_rd, 3, "wr_slverr");
      wait_idle("wr_slverr");
      bresp_c = 2'b01;
      do_req(1'b1, 32'h0088, 64'h6, 8'h80, 1'b1, 1'b0, last_rd, 3, "wr_exokay");
      wait_idle("wr_exokay");
      bresp_c = 2'b00; bid_c = 4'(MID + 1);
      do_req(1'b1, 32'h0090, 64'h7, 8'hFF, 1'b1, 1'b1, last_rd, 3, "wr_bid");
      wait_idle("wr_bid");
      bid_c = 4'(MID);

      rlast_c = 1'b0; rdata_c = 64'h0BAD_0BAD_0BAD_0001;
      do_req(1'b0, 32'h00A0, '0, '0, 1'b1, 1'b1, rdata_c, 3, "rd_nolast");
      wait_idle("rd_nolast");
      rlast_c = 1'b1; rid_c = 4'(MID + 2); rdata_c = 64'h0BAD_0BAD_0BAD_0002;
      do_req(1'b0, 32'h00A8, '0, '0, 1'b1, 1'b1, rdata_c, 3, "rd_rid");
      wait_idle("rd_rid");
      rid_c = 4'(MID); rresp_c = 2'b11; rdata_c = 64'h0BAD_0BAD_0BAD_0003;
      do_req(1'b0, 32'h00B0, '0, '0, 1'b1, 1'b1, rdata_c, 3, "rd_decerr");
      wait_idle("rd_decerr");
      rresp_c = 2'b00;
      last_rd = rdata_c;

      r_en = 1'b0;
      do_req(1'b0, 32'h5000, '0, '0, 1'b0, 1'b0, '0, 0, "rd_abandon");
      repeat (3) @(negedge aclk);
      check("mid_rready_before_rst", axi.rready, 1'b1);
      aresetn = 1'b0;
      @(negedge aclk);
      check("mid_rst_req_ready", req_ready_o, 1'b0);
      check("mid_rst_rready", axi.rready, 1'b0);
      check("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
      check("mid_rst_rsp_dat", rsp_dat_o, 64'd0);
      check("mid_rst_rsp_err", rsp_err_o, 1'b0);
      @(negedge aclk);
      aresetn = 1'b1; r_en = 1'b1; last_rd = '0;
      @(negedge aclk);
      check("post_rst_req_ready", req_ready_o, 1'b1);

      rdata_c = 64'hFEDC_BA98_7654_3210;
      do_req(1'b0, 32'h6000, '0, '0, 1'b1, 1'b0, rdata_c, 3, "rd_after_rst");
      wait_idle("rd_after_rst");
      last_rd = rdata_c;

`ifdef AXI4_SRAM_MST_TIMEOUT_EN
      begin
         int n;
         r_en = 1'b0; rdata_c = 64'h7777_7777_7777_7777;
         do_req(1'b0, 32'h7000, '0, '0, 1'b1, 1'b1, last_rd, TMO + 2, "rd_tmo");
         n = 0;
         while (sb.size() != 0 && n < 100) begin @(negedge aclk); n++; end
         if (sb.size() != 0) begin check("rd_tmo_no_rsp", 1'b0, 1'b1); sb.delete(); end
         for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("rd_tmo_drain_ready", req_ready_o, 1'b0);
         end
         r_en = 1'b1;
         n = 0;
         while (!req_ready_o && n < 20) begin @(negedge aclk); n++; end
         check("rd_tmo_ready_after_late", req_ready_o, 1'b1);
         check("rd_tmo_dat_kept", rsp_dat_o, last_rd);
         repeat (4) @(negedge aclk);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
